// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   state_e          : controller FSM encoding
//   op_e             : latched access direction
//   SRAM_DW          : external SRAM data bus width (half-word)
//   DEF_WAIT_CYCLES  : default number of cycles each half-word phase is held
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int SRAM_DW         = 16;
  localparam int DEF_WAIT_CYCLES = 5;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Bundle of the MEM-stage request/response signals and the external SRAM pins.
//   slave  : controller view (takes requests, drives SRAM pins)
//   master : pipeline + SRAM side view (issues requests, supplies read data)
// Signals:
//   rd_en, wr_en, address, wr_data : MEM-stage request
//   rd_data, ready                 : registered load result, pipeline freeze (0)
//   sram_addr, sram_dq_out, sram_dq_drive, sram_we_n : SRAM outputs
//   sram_dq_in                     : SRAM data bus, read side
interface sram_mem_ctrl_if
  import sram_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 18
) ();

  logic               rd_en;
  logic               wr_en;
  logic [31:0]        address;
  logic [31:0]        wr_data;
  logic [31:0]        rd_data;
  logic               ready;
  logic [ADDR_W-1:0]  sram_addr;
  logic [SRAM_DW-1:0] sram_dq_in;
  logic [SRAM_DW-1:0] sram_dq_out;
  logic               sram_dq_drive;
  logic               sram_we_n;

  modport slave (
    input  rd_en, wr_en, address, wr_data, sram_dq_in,
    output rd_data, ready, sram_addr, sram_dq_out, sram_dq_drive, sram_we_n
  );

  modport master (
    output rd_en, wr_en, address, wr_data, sram_dq_in,
    input  rd_data, ready, sram_addr, sram_dq_out, sram_dq_drive, sram_we_n
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Up-counter timing one half-word phase.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : synchronous clear (wins over en_i)
//   en_i     : count enable
//   tc_o     : high while the count equals TERMINAL
module sram_wait_counter #(
  parameter int WIDTH    = 3,
  parameter int TERMINAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller for a 16-bit asynchronous SRAM.
// Each 32-bit access is split into a low then a high half-word phase, each
// held for WAIT_CYCLES cycles; ready stays low to freeze the pipeline until
// the DONE cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sram_mem_ctrl_if.slave (request, response and SRAM pins)
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  sram_mem_ctrl_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;

  state_e              state_q;
  state_e              state_d;
  logic [ADDR_W-2:0]   addr_q;
  logic [31:0]         data_q;
  op_e                 op_q;
  logic [31:0]         rd_data_q;

  logic                req;
  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_tc;
  logic                in_phase;

  logic [ADDR_W-1:0]   sram_addr;
  logic [SRAM_DW-1:0]  sram_dq_out;
  logic                sram_dq_drive;
  logic                sram_we_n;

  // Byte offset and bits above the SRAM range play no part in addressing.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{bus.address[31:ADDR_W+1], bus.address[1:0]};

  assign req = bus.rd_en | bus.wr_en;

  sram_wait_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (WAIT_CYCLES - 1)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= OP_READ;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        addr_q <= bus.address[ADDR_W:2];
        data_q <= bus.wr_data;
        // A simultaneous read and write request is treated as a write.
        op_q   <= bus.wr_en ? OP_WRITE : OP_READ;
      end
      // Read data is captured on the last count of each phase, after the
      // SRAM has had the full phase to settle.
      if (op_q == OP_READ && cnt_tc) begin
        if (state_q == LOW) begin
          rd_data_q[15:0] <= bus.sram_dq_in;
        end else if (state_q == HIGH) begin
          rd_data_q[31:16] <= bus.sram_dq_in;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    in_phase      = (state_q == LOW) || (state_q == HIGH);
    sram_addr     = '0;
    sram_dq_out   = '0;
    sram_dq_drive = 1'b0;
    sram_we_n     = 1'b1;

    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (req) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (cnt_tc) begin
          state_d = HIGH;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_tc) begin
          state_d = DONE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    // SRAM pins decode only from registered state, so request inputs never
    // reach the pins combinationally.
    if (in_phase) begin
      sram_addr = {addr_q, (state_q == HIGH)};
      if (op_q == OP_WRITE) begin
        sram_dq_drive = 1'b1;
        sram_dq_out   = (state_q == HIGH) ? data_q[31:16] : data_q[15:0];
        // Strobe released on the last count so data is held past we_n rising.
        sram_we_n     = cnt_tc;
      end
    end
  end

  assign bus.sram_addr     = sram_addr;
  assign bus.sram_dq_out   = sram_dq_out;
  assign bus.sram_dq_drive = sram_dq_drive;
  assign bus.sram_we_n     = sram_we_n;
  assign bus.rd_data       = rd_data_q;
  assign bus.ready         = (state_q == DONE) || (state_q == IDLE && !req);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Testbench for sram_mem_ctrl (ADDR_W = 18, WAIT_CYCLES = 5) with a
// behavioural 16-bit SRAM attached to the controller pins.
module tb_sram_mem_ctrl;

  localparam int AW = 18;
  localparam int W  = 5;

  logic clk;
  logic rst;

  sram_mem_ctrl_if #(.ADDR_W(AW)) bus ();

  sram_mem_ctrl #(
    .ADDR_W      (AW),
    .WAIT_CYCLES (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM: combinational read, write while we_n low.
  bit [15:0] mem [0:(1<<AW)-1];
  assign bus.sram_dq_in = mem[bus.sram_addr];
  always @(posedge clk) begin
    if (bus.sram_we_n == 1'b0 && bus.sram_dq_drive == 1'b1) begin
      mem[bus.sram_addr] <= bus.sram_dq_out;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        is_wr;   // expected to be performed as a write
    logic [17:0] exp_sa;  // SRAM address of the low half
    logic [15:0] exp_lo;  // SRAM content at exp_sa after the access
    logic [15:0] exp_hi;  // SRAM content at exp_sa+1 after the access
    logic [31:0] exp_rd;  // rd_data in the DONE cycle
  } vec_t;

  vec_t vecs [6];

  // Packs {sram_addr, dq_out, we_n, drive, ready} for one compare.
  function automatic logic [63:0] pins();
    return {27'd0, bus.sram_addr, bus.sram_dq_out, bus.sram_we_n, bus.sram_dq_drive, bus.ready};
  endfunction

  function automatic logic [63:0] mk(input logic [17:0] sa, input logic [15:0] d,
                                     input logic we_n, input logic drv, input logic rdy);
    return {27'd0, sa, d, we_n, drv, rdy};
  endfunction

  // One full access starting at cycle 0; checks every cycle through DONE.
  task automatic run_access(input vec_t v, input int idx);
    logic        hi;
    int          cnt;
    logic [17:0] sa;
    logic [15:0] d;
    logic        we_n;
    logic        drv;
    @(posedge clk); #1;
    bus.rd_en   = v.rd;
    bus.wr_en   = v.wr;
    bus.address = v.addr;
    bus.wr_data = v.wdata;
    @(negedge clk);
    check($sformatf("v%0d_req_ready", idx), {63'd0, bus.ready}, 64'd0);
    for (int c = 1; c <= 2*W; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.address = 32'hFFFF_FFFF;
        bus.wr_data = 32'h0BAD_0BAD;
      end
      hi  = (c > W);
      cnt = (c - 1) % W;
      sa  = v.exp_sa | {17'd0, hi};
      if (v.is_wr) begin
        d    = hi ? v.exp_hi : v.exp_lo;
        we_n = (cnt == W - 1);
        drv  = 1'b1;
      end else begin
        d    = 16'd0;
        we_n = 1'b1;
        drv  = 1'b0;
      end
      check($sformatf("v%0d_cyc%0d_pins", idx, c), pins(), mk(sa, d, we_n, drv, 1'b0));
    end
    @(negedge clk);
    check($sformatf("v%0d_done_pins", idx), pins(), mk(18'd0, 16'd0, 1'b1, 1'b0, 1'b1));
    check($sformatf("v%0d_rd_data", idx), {32'd0, bus.rd_data}, {32'd0, v.exp_rd});
    check($sformatf("v%0d_mem_lo", idx), {48'd0, mem[v.exp_sa]}, {48'd0, v.exp_lo});
    check($sformatf("v%0d_mem_hi", idx), {48'd0, mem[v.exp_sa + 18'd1]}, {48'd0, v.exp_hi});
    @(negedge clk);
    check($sformatf("v%0d_idle_ready", idx), {63'd0, bus.ready}, 64'd1);
  endtask

  initial begin
    //          rd    wr    addr          wdata         is_wr exp_sa    lo        hi        rd_data
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 1'b1, 18'h204, 16'hBEEF, 16'hDEAD, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0000_0000, 1'b0, 18'h204, 16'hBEEF, 16'hDEAD, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, 18'h008, 16'h5678, 16'h1234, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 18'h008, 16'h5678, 16'h1234, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b1, 32'hFFF8_0020, 32'hCAFE_F00D, 1'b1, 18'h010, 16'hF00D, 16'hCAFE, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 18'h010, 16'hF00D, 16'hCAFE, 32'hCAFE_F00D};

    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.address = 32'd0;
    bus.wr_data = 32'd0;
    rst         = 1'b1;

    // Reset held two cycles with no request.
    @(posedge clk);
    @(negedge clk);
    check("rst1_pins", pins(), mk(18'd0, 16'd0, 1'b1, 1'b0, 1'b1));
    check("rst1_rd_data", {32'd0, bus.rd_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_pins", pins(), mk(18'd0, 16'd0, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    check("post_rst_pins", pins(), mk(18'd0, 16'd0, 1'b1, 1'b0, 1'b1));
    check("post_rst_rd_data", {32'd0, bus.rd_data}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_access(vecs[i], i);
    end

    // Reset asserted in cycle 3 of a store.
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.address = 32'h0000_0100;
    bus.wr_data = 32'h1111_2222;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cyc3_pins", pins(), mk(18'h080, 16'h2222, 1'b0, 1'b1, 1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_after_pins", pins(), mk(18'd0, 16'd0, 1'b1, 1'b0, 1'b1));
    check("midrst_rd_data", {32'd0, bus.rd_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_released_pins", pins(), mk(18'd0, 16'd0, 1'b1, 1'b0, 1'b1));

    // Back-to-back store then load with requests held continuously.
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b0;
    bus.address = 32'h0000_0200;
    bus.wr_data = 32'hA5A5_5A5A;
    for (int c = 0; c <= 4*W + 3; c++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_cyc%0d", c), {63'd0, bus.ready},
            {63'd0, (c == 2*W + 1) || (c == 4*W + 3)});
      if (c == 2*W + 1) begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
      end
      if (c == 2*W + 3) begin
        check("b2b_load_low_pins", pins(), mk(18'h100, 16'd0, 1'b1, 1'b0, 1'b0));
      end
      if (c == 4*W + 3) begin
        check("b2b_rd_data", {32'd0, bus.rd_data}, {32'd0, 32'hA5A5_5A5A});
        bus.rd_en = 1'b0;
      end
    end
    check("b2b_mem_lo", {48'd0, mem[18'h100]}, {48'd0, 16'h5A5A});
    check("b2b_mem_hi", {48'd0, mem[18'h101]}, {48'd0, 16'hA5A5});
    @(negedge clk);
    check("b2b_idle_ready", {63'd0, bus.ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
